// File: rtl/nfifo_rr_scheduler.sv
// Read-side scheduler for mem2nfifo: round-robin burst grants over the per-flow
// FIFOs, with a 2-entry skid buffer that merges returned words into one tagged stream.
module nfifo_rr_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter int BURST      = 8,
  localparam int FLOW_WIDTH = $clog2(FLOWS)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [FLOWS-1:0]            FIFO_EMPTY,
  output logic [FLOWS-1:0]            FIFO_READ,
  input  logic [FLOWS*DATA_WIDTH-1:0] FIFO_DATA,
  input  logic [FLOWS-1:0]            FIFO_DATA_VLD,
  input  logic [FLOWS-1:0]            ENABLE,
  output logic [DATA_WIDTH-1:0]       TX_DATA,
  output logic [FLOW_WIDTH-1:0]       TX_FLOW,
  output logic                        TX_SRC_RDY,
  input  logic                        TX_DST_RDY,
  output logic                        IDLE
);

  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE_ST, BURST_ST} state_t;

  state_t                  state_q, state_d;
  logic [FLOW_WIDTH-1:0]   ptr_q, ptr_d;
  logic [FLOW_WIDTH-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    infl_q, infl_d;
  logic [FLOW_WIDTH-1:0]   infl_flow_q, infl_flow_d;
  logic                    head_vld_q, head_vld_d;
  logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
  logic [FLOW_WIDTH-1:0]   head_flow_q, head_flow_d;
  logic                    tail_vld_q, tail_vld_d;
  logic [DATA_WIDTH-1:0]   tail_data_q, tail_data_d;
  logic [FLOW_WIDTH-1:0]   tail_flow_q, tail_flow_d;

  logic [FLOWS-1:0]        eligible;
  logic [DATA_WIDTH-1:0]   slice [FLOWS];
  logic [1:0]              occ;
  logic                    consume;
  logic                    credit;
  logic                    found;
  logic [FLOW_WIDTH-1:0]   next_flow;
  logic                    rd_en;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;

  for (genvar i = 0; i < FLOWS; i++) begin : g_slice
    assign slice[i] = FIFO_DATA[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH];
  end

  assign eligible = ENABLE & ~FIFO_EMPTY;
  assign occ      = 2'(head_vld_q) + 2'(tail_vld_q);
  assign consume  = head_vld_q & TX_DST_RDY;
  // Counting the word leaving this cycle keeps full rate; this is a comb path from TX_DST_RDY.
  assign credit   = (3'(occ) + 3'(infl_q)) < (3'd2 + 3'(consume));
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign wr_en    = infl_q & FIFO_DATA_VLD[infl_flow_q];
  assign wr_data  = slice[infl_flow_q];

  always_comb begin : p_search
    logic [FLOW_WIDTH-1:0] idx;
    found     = 1'b0;
    next_flow = '0;
    idx       = '0;
    for (int k = 1; k <= FLOWS; k++) begin
      idx = ptr_q + FLOW_WIDTH'(k);
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        next_flow = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE_ST: begin
        if (found) begin
          grant_d = next_flow;
          cnt_d   = '0;
          state_d = BURST_ST;
        end
      end
      BURST_ST: begin
        if (eligible[grant_q] && credit) begin
          rd_en = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(BURST)) begin
            state_d = IDLE_ST;
            ptr_d   = grant_q;
          end
        end else if (!eligible[grant_q]) begin
          state_d = IDLE_ST;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // A read in the reset cycle would pop a word that the reset then discards.
  assign FIFO_READ   = (rd_en && RESET) ? (FLOWS'(1) << grant_q) : '0;
  assign infl_d      = rd_en & RESET;
  assign infl_flow_d = grant_q;

  always_comb begin
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    head_flow_d = head_flow_q;
    tail_vld_d  = tail_vld_q;
    tail_data_d = tail_data_q;
    tail_flow_d = tail_flow_q;
    if (consume) begin
      if (tail_vld_q) begin
        head_data_d = tail_data_q;
        head_flow_d = tail_flow_q;
        if (wr_en) begin
          tail_data_d = wr_data;
          tail_flow_d = infl_flow_q;
        end else begin
          tail_vld_d = 1'b0;
        end
      end else if (wr_en) begin
        head_data_d = wr_data;
        head_flow_d = infl_flow_q;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (wr_en) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = wr_data;
        head_flow_d = infl_flow_q;
      end else begin
        tail_vld_d  = 1'b1;
        tail_data_d = wr_data;
        tail_flow_d = infl_flow_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE_ST;
      ptr_q       <= '1;
      grant_q     <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_flow_q <= '0;
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_flow_q <= '0;
      tail_vld_q  <= 1'b0;
      tail_data_q <= '0;
      tail_flow_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_flow_q <= infl_flow_d;
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      head_flow_q <= head_flow_d;
      tail_vld_q  <= tail_vld_d;
      tail_data_q <= tail_data_d;
      tail_flow_q <= tail_flow_d;
    end
  end

  assign TX_DATA    = head_data_q;
  assign TX_FLOW    = head_flow_q;
  assign TX_SRC_RDY = head_vld_q;
  assign IDLE       = (state_q == IDLE_ST) && !infl_q && (occ == 2'd0);

endmodule
